// File: rtl/ap_seq_pkg.sv
// Shared types, default widths and the wrap-safe cycle difference used by
// the ap_ctrl_chain sequencer and its timestamp FIFO.
package ap_seq_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int TXN_W_DEF = 16;
    localparam int DEPTH_DEF = 4;
    localparam int DIFF_W    = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } seq_state_e;

    // Callers zero-extend narrower counters and truncate the result, which
    // yields the modulo-2^CNT_W difference for any CNT_W up to DIFF_W.
    function automatic logic [DIFF_W-1:0] mod_diff(input logic [DIFF_W-1:0] later,
                                                   input logic [DIFF_W-1:0] earlier);
        return later - earlier;
    endfunction

endpackage

// File: rtl/txn_ts_fifo.sv
// Start-timestamp FIFO: one entry per outstanding transaction, head visible
// on rdata without a read latency.
module txn_ts_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = mem[rd_ptr];

    // NOTE: storage carries no reset; only pointers and count define validity.
    always_ff @(posedge ap_clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/ap_ctrl_sequencer.sv
// ap_ctrl_chain initiator: issues a programmed number of kernel starts with
// overlap, then reports per-transaction latency, start interval and min/max.
module ap_ctrl_sequencer
    import ap_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TXN_W = TXN_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             cfg_go,
    input  logic [TXN_W-1:0] cfg_num_txn,
    input  logic             cfg_abort,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_continue,
    output logic             busy,
    output logic             run_done,
    output logic [TXN_W-1:0] txn_issued,
    output logic [TXN_W-1:0] txn_completed,
    output logic             lat_valid,
    output logic [CNT_W-1:0] lat_value,
    output logic [CNT_W-1:0] ii_value,
    output logic [CNT_W-1:0] lat_min,
    output logic [CNT_W-1:0] lat_max,
    output logic             err_spurious
);
    localparam int CW = $clog2(DEPTH) + 1;

    seq_state_e       state;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] last_start;
    logic [CNT_W-1:0] head_ts;
    logic [CNT_W-1:0] lat_now;
    logic [CNT_W-1:0] ii_now;
    logic [TXN_W-1:0] num_txn;
    logic [TXN_W-1:0] issued_next;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             start_hs;
    logic             comp;
    logic             comp_ok;
    logic             bypass;
    logic             push;
    logic             pop;
    logic             full_next;
    logic             abort_q;
    logic             stop;

    assign ap_continue = (state == ISSUE) || (state == DRAIN);
    assign busy        = ap_continue;

    // NOTE: combinational next-value logic uses blocking '=', registers use '<='.
    always_comb begin
        start_hs    = ap_start & ap_ready;
        comp        = ap_done & ap_continue;
        bypass      = comp & start_hs & fifo_empty;
        comp_ok     = comp & (~fifo_empty | start_hs);
        push        = start_hs & ~bypass;
        pop         = comp & ~fifo_empty;
        stop        = cfg_abort | abort_q;
        issued_next = txn_issued + TXN_W'(start_hs);
        full_next   = fifo_full ? !pop
                                : (push && !pop && (fifo_count == CW'(DEPTH - 1)));
        lat_now     = bypass ? '0 : CNT_W'(mod_diff(DIFF_W'(cyc), DIFF_W'(head_ts)));
        ii_now      = CNT_W'(mod_diff(DIFF_W'(cyc), DIFF_W'(last_start)));
    end

    txn_ts_fifo #(
        .DEPTH (DEPTH),
        .W     (CNT_W)
    ) u_ts_fifo (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .push     (push),
        .pop      (pop),
        .wdata    (cyc),
        .rdata    (head_ts),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) cyc <= '0;
        else           cyc <= cyc + CNT_W'(1);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state         <= IDLE;
            ap_start      <= 1'b0;
            run_done      <= 1'b0;
            num_txn       <= '0;
            txn_issued    <= '0;
            txn_completed <= '0;
            lat_valid     <= 1'b0;
            lat_value     <= '0;
            ii_value      <= '0;
            lat_min       <= '1;
            lat_max       <= '0;
            err_spurious  <= 1'b0;
            last_start    <= '0;
            abort_q       <= 1'b0;
        end else begin
            run_done  <= 1'b0;
            lat_valid <= 1'b0;

            if (start_hs) begin
                txn_issued <= issued_next;
                ii_value   <= (txn_issued == '0) ? '0 : ii_now;
                last_start <= cyc;
            end

            if (comp_ok) begin
                lat_valid     <= 1'b1;
                lat_value     <= lat_now;
                txn_completed <= txn_completed + TXN_W'(1);
                if (lat_now < lat_min) lat_min <= lat_now;
                if (lat_now > lat_max) lat_max <= lat_now;
            end else if (comp) begin
                err_spurious <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cfg_go) begin
                        num_txn       <= cfg_num_txn;
                        txn_issued    <= '0;
                        txn_completed <= '0;
                        ii_value      <= '0;
                        lat_min       <= '1;
                        lat_max       <= '0;
                        err_spurious  <= 1'b0;
                        abort_q       <= 1'b0;
                        ap_start      <= (cfg_num_txn != '0);
                        state         <= (cfg_num_txn == '0) ? FINISH : ISSUE;
                    end
                end
                ISSUE: begin
                    abort_q <= stop;
                    if (issued_next == num_txn) begin
                        ap_start <= 1'b0;
                        state    <= DRAIN;
                    end else if (stop && (!ap_start || start_hs)) begin
                        ap_start <= 1'b0;
                        state    <= DRAIN;
                    end else begin
                        // A raised start is held until accepted; a new one needs room.
                        ap_start <= (ap_start && !start_hs) || (!stop && !full_next);
                    end
                end
                DRAIN: begin
                    if ((txn_completed == txn_issued) && !comp) state <= FINISH;
                end
                FINISH: begin
                    run_done <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// Directed bench for ap_ctrl_sequencer: a cycle-stepped kernel model drives
// ap_ready/ap_done and each scenario task checks its hand-derived results.
module tb_ap_ctrl_sequencer;

    localparam int DEPTH = 4;
    localparam int M_OFF = 0;
    localparam int M_NP  = 1;
    localparam int M_PL  = 2;
    localparam int M_AB  = 3;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        cfg_go;
    logic [15:0] cfg_num_txn;
    logic        cfg_abort;
    logic        ap_start;
    logic        ap_ready;
    logic        ap_done;
    logic        ap_continue;
    logic        busy;
    logic        run_done;
    logic [15:0] txn_issued;
    logic [15:0] txn_completed;
    logic        lat_valid;
    logic [31:0] lat_value;
    logic [31:0] ii_value;
    logic [31:0] lat_min;
    logic [31:0] lat_max;
    logic        err_spurious;

    int checks = 0;
    int errors = 0;

    // kernel model and tallies
    int   mode = M_OFF;
    int   k_lat = 10;
    int   kcyc = 0;
    int   go_k = 0;
    int   go_num = 0;
    logic go_pending = 1'b0;
    logic force_done = 1'b0;
    logic prev_start = 1'b0;
    logic prev_hs = 1'b0;
    int   done_q[$];
    int   n_hs, n_start, n_lat, n_lat_bad, n_run_done, n_busy, n_full_viol, max_out;
    int   rd_k, last_start_k;

    ap_ctrl_sequencer dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .cfg_go        (cfg_go),
        .cfg_num_txn   (cfg_num_txn),
        .cfg_abort     (cfg_abort),
        .ap_start      (ap_start),
        .ap_ready      (ap_ready),
        .ap_done       (ap_done),
        .ap_continue   (ap_continue),
        .busy          (busy),
        .run_done      (run_done),
        .txn_issued    (txn_issued),
        .txn_completed (txn_completed),
        .lat_valid     (lat_valid),
        .lat_value     (lat_value),
        .ii_value      (ii_value),
        .lat_min       (lat_min),
        .lat_max       (lat_max),
        .err_spurious  (err_spurious)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // One cycle: observe outputs mid-cycle, drive the kernel response for this cycle.
    task automatic step();
        logic rdy;
        logic dn;
        logic hs;
        int   out_now;
        @(negedge ap_clk);
        kcyc++;
        cfg_go = go_pending;
        if (go_pending) begin
            cfg_num_txn = 16'(go_num);
            go_k        = kcyc;
        end
        go_pending = 1'b0;
        out_now = done_q.size();
        dn = 1'b0;
        if (out_now > 0 && done_q[0] == kcyc) begin
            dn = 1'b1;
            void'(done_q.pop_front());
        end
        case (mode)
            M_NP:    rdy = (out_now == 0) || dn;
            M_PL:    rdy = prev_start && !prev_hs;
            M_AB:    rdy = (kcyc >= go_k + 6);
            default: rdy = 1'b0;
        endcase
        if (force_done) dn = 1'b1;
        force_done = 1'b0;
        ap_ready = rdy;
        ap_done  = dn;
        hs = ap_start && rdy;
        if (hs) begin
            n_hs++;
            done_q.push_back(kcyc + k_lat);
        end
        if (ap_start) begin
            n_start++;
            last_start_k = kcyc;
            if (out_now == DEPTH) n_full_viol++;
        end
        if (out_now > max_out) max_out = out_now;
        if (lat_valid) begin
            n_lat++;
            if (lat_value !== 32'(k_lat)) n_lat_bad++;
        end
        if (run_done) begin
            n_run_done++;
            rd_k = kcyc;
        end
        if (busy) n_busy++;
        prev_start = ap_start;
        prev_hs    = hs;
    endtask

    task automatic clear_tallies();
        n_hs = 0; n_start = 0; n_lat = 0; n_lat_bad = 0; n_run_done = 0;
        n_busy = 0; n_full_viol = 0; max_out = 0; rd_k = -1; last_start_k = -1;
    endtask

    task automatic go(input int num);
        go_pending = 1'b1;
        go_num     = num;
    endtask

    task automatic wait_run_done(input int budget, input string tag);
        int n0 = n_run_done;
        int i  = 0;
        while (n_run_done == n0 && i < budget) begin
            step();
            i++;
        end
        checks++;
        if (n_run_done == n0) begin
            errors++;
            $display("FAIL %s_timeout: got no run_done in %0d cycles, expected one", tag, budget);
        end
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0; cfg_go = 1'b0; cfg_num_txn = '0; cfg_abort = 1'b0;
        ap_ready = 1'b0; ap_done = 1'b0;
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        step();
        checks++;
        if ({ap_start, ap_continue, busy, run_done, lat_valid, err_spurious} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, expected 000000",
                     {ap_start, ap_continue, busy, run_done, lat_valid, err_spurious});
        end
        checks++;
        if (txn_issued !== 16'd0 || txn_completed !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d, expected 0/0", txn_issued, txn_completed);
        end
        checks++;
        if (lat_value !== 32'd0 || ii_value !== 32'd0 || lat_max !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats: got lat %0d ii %0d max %0d, expected 0 0 0",
                     lat_value, ii_value, lat_max);
        end
        checks++;
        if (lat_min !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL reset_lat_min: got %h, expected ffffffff", lat_min);
        end
    endtask

    task automatic run_non_pipelined(input string tag);
        clear_tallies();
        mode = M_NP; k_lat = 10;
        go(3);
        wait_run_done(200, tag);
        repeat (3) step();
        checks++;
        if (n_lat !== 3) begin
            errors++; $display("FAIL %s_lat_count: got %0d, expected 3", tag, n_lat);
        end
        checks++;
        if (n_lat_bad !== 0) begin
            errors++; $display("FAIL %s_lat_value: got %0d wrong latencies, expected 0 (lat 10)", tag, n_lat_bad);
        end
        checks++;
        if (ii_value !== 32'd10) begin
            errors++; $display("FAIL %s_ii: got %0d, expected 10", tag, ii_value);
        end
        checks++;
        if (txn_completed !== 16'd3 || txn_issued !== 16'd3) begin
            errors++; $display("FAIL %s_counts: got %0d/%0d, expected 3/3", tag, txn_issued, txn_completed);
        end
        checks++;
        if (n_run_done !== 1) begin
            errors++; $display("FAIL %s_run_done: got %0d pulses, expected 1", tag, n_run_done);
        end
        checks++;
        if (lat_min !== 32'd10 || lat_max !== 32'd10) begin
            errors++; $display("FAIL %s_minmax: got %0d/%0d, expected 10/10", tag, lat_min, lat_max);
        end
        checks++;
        if (err_spurious !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL %s_idle: got err %b busy %b, expected 0 0", tag, err_spurious, busy);
        end
    endtask

    task automatic test_non_pipelined();
        run_non_pipelined("np");
    endtask

    task automatic test_pipelined();
        clear_tallies();
        mode = M_PL; k_lat = 8;
        go(6);
        wait_run_done(300, "pl");
        checks++;
        if (n_lat !== 6 || n_lat_bad !== 0) begin
            errors++; $display("FAIL pl_lat: got %0d pulses %0d wrong, expected 6 pulses 0 wrong", n_lat, n_lat_bad);
        end
        checks++;
        if (max_out !== DEPTH) begin
            errors++; $display("FAIL pl_fill: got max outstanding %0d, expected %0d", max_out, DEPTH);
        end
        checks++;
        if (n_full_viol !== 0) begin
            errors++; $display("FAIL pl_start_when_full: got %0d cycles, expected 0", n_full_viol);
        end
        checks++;
        if (ii_value !== 32'd2) begin
            errors++; $display("FAIL pl_ii: got %0d, expected 2", ii_value);
        end
        checks++;
        if (txn_completed !== 16'd6 || err_spurious !== 1'b0) begin
            errors++; $display("FAIL pl_done: got completed %0d err %b, expected 6 0", txn_completed, err_spurious);
        end
        checks++;
        if (lat_min !== 32'd8 || lat_max !== 32'd8) begin
            errors++; $display("FAIL pl_minmax: got %0d/%0d, expected 8/8", lat_min, lat_max);
        end
    endtask

    task automatic test_zero_txn();
        clear_tallies();
        mode = M_OFF;
        go(0);
        repeat (6) step();
        checks++;
        if (n_run_done !== 1) begin
            errors++; $display("FAIL zero_run_done: got %0d pulses, expected 1", n_run_done);
        end
        checks++;
        if (rd_k - go_k !== 2) begin
            errors++; $display("FAIL zero_timing: got run_done %0d cycles after go, expected 2", rd_k - go_k);
        end
        checks++;
        if (n_busy !== 0 || n_start !== 0) begin
            errors++; $display("FAIL zero_quiet: got busy %0d start %0d cycles, expected 0 0", n_busy, n_start);
        end
    endtask

    task automatic test_abort();
        clear_tallies();
        mode = M_AB; k_lat = 3;
        go(4);
        step();
        step();
        cfg_abort = 1'b1;
        wait_run_done(100, "abort");
        repeat (2) step();
        checks++;
        if (n_start !== 6 || last_start_k - go_k !== 6) begin
            errors++; $display("FAIL abort_hold: got %0d start cycles ending at +%0d, expected 6 ending at +6",
                               n_start, last_start_k - go_k);
        end
        checks++;
        if (n_hs !== 1) begin
            errors++; $display("FAIL abort_starts: got %0d handshakes, expected 1", n_hs);
        end
        checks++;
        if (txn_issued !== 16'd1 || txn_completed !== 16'd1) begin
            errors++; $display("FAIL abort_counts: got %0d/%0d, expected 1/1", txn_issued, txn_completed);
        end
        checks++;
        if (n_lat !== 1 || n_lat_bad !== 0 || err_spurious !== 1'b0) begin
            errors++; $display("FAIL abort_lat: got %0d pulses %0d wrong err %b, expected 1 0 0",
                               n_lat, n_lat_bad, err_spurious);
        end
        cfg_abort = 1'b0;
    endtask

    task automatic test_spurious();
        clear_tallies();
        mode = M_OFF; k_lat = 3;
        go(2);
        step();
        step();
        force_done = 1'b1;
        step();
        step();
        checks++;
        if (err_spurious !== 1'b1) begin
            errors++; $display("FAIL spur_flag: got %b, expected 1", err_spurious);
        end
        checks++;
        if (txn_completed !== 16'd0 || n_lat !== 0) begin
            errors++; $display("FAIL spur_counts: got completed %0d pulses %0d, expected 0 0", txn_completed, n_lat);
        end
        mode = M_AB;
        cfg_abort = 1'b1;
        wait_run_done(100, "spur_end");
        checks++;
        if (err_spurious !== 1'b1 || txn_completed !== 16'd1) begin
            errors++; $display("FAIL spur_sticky: got err %b completed %0d, expected 1 1", err_spurious, txn_completed);
        end
        cfg_abort = 1'b0;
        go(0);
        wait_run_done(20, "spur_clear");
        checks++;
        if (err_spurious !== 1'b0) begin
            errors++; $display("FAIL spur_clear: got %b, expected 0", err_spurious);
        end
    endtask

    task automatic test_reset_mid_drain();
        int i = 0;
        clear_tallies();
        mode = M_PL; k_lat = 8;
        go(6);
        while (n_hs < 6 && i < 200) begin
            step();
            i++;
        end
        checks++;
        if (n_hs !== 6) begin
            errors++; $display("FAIL rst_issue: got %0d handshakes, expected 6", n_hs);
        end
        repeat (2) step();
        #2 ap_rst_n = 1'b0;
        #1;
        checks++;
        if ({ap_start, ap_continue, busy, lat_valid} !== 4'b0) begin
            errors++; $display("FAIL rst_async_ctrl: got %b, expected 0000", {ap_start, ap_continue, busy, lat_valid});
        end
        checks++;
        if (txn_issued !== 16'd0 || txn_completed !== 16'd0 || lat_max !== 32'd0) begin
            errors++; $display("FAIL rst_async_cnt: got %0d/%0d max %0d, expected 0/0 max 0",
                               txn_issued, txn_completed, lat_max);
        end
        checks++;
        if (lat_min !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL rst_async_min: got %h, expected ffffffff", lat_min);
        end
        done_q.delete();
        mode = M_OFF;
        prev_start = 1'b0;
        prev_hs    = 1'b0;
        ap_ready   = 1'b0;
        ap_done    = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        run_non_pipelined("post_rst");
    endtask

    initial begin
        test_reset();
        test_non_pipelined();
        test_pipelined();
        test_zero_txn();
        test_abort();
        test_spurious();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ap_ctrl_sequencer.md
Name: ap_ctrl_sequencer

Overview:
- Synthesizable initiator for the HLS block-level ap_ctrl_chain handshake (ap_start/ap_ready/ap_done/ap_continue).
- Issues a programmed number of transactions to an HLS kernel and supports overlapped starts for pipelined kernels.
- Time-stamps every start, and reports per-transaction latency, start-to-start interval (II) and min/max latency.
- Sits between a host/control register block and a kernel top (e.g. matrixmul). It drives the signals the dataflow monitors only observe.

Parameters:
- CNT_W, 32, width of free-running cycle counter and all latency/II values.
- TXN_W, 16, width of transaction count registers.
- DEPTH, 4, maximum outstanding (started, not completed) transactions; power of two, ≥2.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  reset, asynchronous, active-low.
- cfg_go  in  1  single-cycle pulse; starts a run.
- cfg_num_txn  in  TXN_W  transactions per run; sampled on accepted cfg_go.
- cfg_abort  in  1  level; stop issuing new starts.
- ap_start  out  1  to kernel.
- ap_ready  in  1  from kernel.
- ap_done  in  1  from kernel.
- ap_continue  out  1  to kernel.
- busy  out  1  run in progress.
- run_done  out  1  one-cycle pulse at end of run.
- txn_issued  out  TXN_W  count of start handshakes in current run.
- txn_completed  out  TXN_W  count of completions in current run.
- lat_valid  out  1  one-cycle pulse per completion.
- lat_value  out  CNT_W  latency of completing transaction.
- ii_value  out  CNT_W  cycles between last two start handshakes.
- lat_min  out  CNT_W  minimum latency in run.
- lat_max  out  CNT_W  maximum latency in run.
- err_spurious  out  1  sticky; ap_done with nothing outstanding.

Behaviour:
- Reset values: all outputs 0 except lat_min, which resets to all-ones. FSM = IDLE, FIFO empty, cyc = 0.
- cyc: free-running, increments every cycle. Differences use modulo-2^CNT_W subtraction, so results are exact while the true value is < 2^CNT_W.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE: on cfg_go, latch cfg_num_txn and clear counters, lat_min (to all-ones), lat_max and ii_value.
  - If cfg_num_txn == 0, go to FINISH.
  - Otherwise go to ISSUE.
  - cfg_go while busy is ignored.
- ISSUE: ap_start (registered) is high while txn_issued < num and FIFO is not full.
  - Start handshake = ap_start & ap_ready in the same cycle. On a handshake: push cyc into the FIFO, increment txn_issued, set ii_value = cyc − previous start cyc (0 for the first start of a run).
  - ap_start deasserts in the cycle after the last required handshake, or after a handshake that fills the FIFO.
  - Go to DRAIN when txn_issued reaches num, or when cfg_abort is seen with ap_start low.
  - If cfg_abort is seen while ap_start is high, ap_start stays high until its handshake completes; no new starts follow. ap_start never drops without ap_ready.
- ap_continue = 1 in ISSUE and DRAIN, 0 in IDLE and FINISH.
- Completion = ap_done & ap_continue. On completion: pop the FIFO, lat_value = cyc − popped timestamp, pulse lat_valid the next cycle, increment txn_completed, update lat_min/lat_max.
- Push and pop in the same cycle are both performed.
- If the FIFO is empty and a push occurs in the same cycle as a completion, the pushed value bypasses the FIFO and latency = 0.
- Completion with an empty FIFO and no same-cycle push: set err_spurious and do not change counters.
- DRAIN: ap_start = 0. Go to FINISH when txn_completed == txn_issued and no completion is pending.
- FINISH: pulse run_done for one cycle, then go to IDLE. busy = 1 in ISSUE and DRAIN only.
- Counters and statistics hold their values after the run until the next accepted cfg_go. err_spurious is cleared only by reset or an accepted cfg_go.
- ap_rst_n assertion mid-run: everything returns to reset values immediately, including ap_start = 0. In-flight transactions are forgotten.

Decomposition:
- Package ap_seq_pkg holds:
  - the state enum type (IDLE, ISSUE, DRAIN, FINISH);
  - default width constants;
  - a function for modular difference.
- Sub-module txn_ts_fifo: synchronous FIFO, DEPTH × CNT_W, with push/pop/full/empty. Simultaneous push/pop is allowed when full or empty (push ignored when full without pop). Reset is asynchronous active-low.

Test Plan:
- Non-pipelined kernel model: ready = done, 10 cycles after start; num=3 → three lat_valid, lat_value=10 each, ii_value=10 after the third start, run_done once, txn_completed=3.
- Pipelined kernel model: ready 1 cycle after start, done 8 cycles after start, num=6, DEPTH=4 → ap_start held low while 4 are outstanding, lat_value=8 for all, no err.
- num=0 → run_done pulses 2 cycles after cfg_go, ap_start never asserted, busy stays 0.
- cfg_abort asserted while ap_start is high and ready is withheld 5 cycles → ap_start stays high until ready, no further starts, DRAIN completes, txn_issued = txn_completed.
- Spurious ap_done in ISSUE with FIFO empty → err_spurious=1, txn_completed unchanged; next cfg_go clears it.
- ap_rst_n pulsed low mid-DRAIN → outputs return to reset values asynchronously, lat_min = all-ones; a new run then behaves as in scenario 1.
